// File: rtl/pattern_broadcaster.sv
// Drives operand buses a/b and cin for a datapath under test from two scan pins (broadcast, serial, walking-one).
// BCAST completes in 1 cycle, SERIAL/WALK in N cycles; no backpressure, start is ignored while busy.
module pattern_broadcaster #(
  parameter int N = 16,
  localparam int CNT_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   mode,
  input  logic         start,
  input  logic         pin_a,
  input  logic         pin_b,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic         cin,
  output logic         busy,
  output logic         done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] MODE_BCAST  = 2'b00;
  localparam logic [1:0] MODE_SERIAL = 2'b01;
  localparam logic [1:0] MODE_WALK   = 2'b10;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [N-1:0]       a_d, b_d;
  logic               cin_d, done_d;
  logic               cnt_last;

  assign cnt_last = (cnt_q == CNT_W'(N - 1));
  assign busy     = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    a_d     = a;
    b_d     = b;
    cin_d   = cin;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && (mode != 2'b11)) begin
          cin_d  = pin_a;
          mode_d = mode;
          case (mode)
            MODE_BCAST: begin
              a_d    = {N{pin_a}};
              b_d    = {N{pin_b}};
              done_d = 1'b1;
            end
            MODE_SERIAL: begin
              a_d     = {pin_a, a[N-1:1]};
              b_d     = {pin_b, b[N-1:1]};
              cnt_d   = CNT_W'(1);
              state_d = RUN;
            end
            MODE_WALK: begin
              a_d     = {{(N-1){1'b0}}, 1'b1};
              b_d     = {N{pin_b}};
              cnt_d   = CNT_W'(1);
              state_d = RUN;
            end
            default: ;
          endcase
        end
      end

      RUN: begin
        // mode_q was captured at start; the live mode input is ignored here
        if (mode_q == MODE_SERIAL) begin
          a_d = {pin_a, a[N-1:1]};
          b_d = {pin_b, b[N-1:1]};
        end else begin
          a_d = a << 1;
        end
        if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_BCAST;
      a       <= '0;
      b       <= '0;
      cin     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      a       <= a_d;
      b       <= b_d;
      cin     <= cin_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_pattern_broadcaster.sv
// Self-checking bench for pattern_broadcaster: directed scenarios plus random traffic against a behavioural model.
module tb_pattern_broadcaster;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst, start, pin_a, pin_b;
  logic [1:0]   mode;
  logic [N-1:0] a, b;
  logic         cin, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: remaining-cycles counter and operation kind
  logic [N-1:0] m_a, m_b;
  logic         m_cin, m_done;
  int           m_left, m_op;

  pattern_broadcaster #(.N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .start(start),
    .pin_a(pin_a),
    .pin_b(pin_b),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic [1:0] md,
                            input logic pa, input logic pb);
    if (r) begin
      m_a = '0; m_b = '0; m_cin = 1'b0; m_done = 1'b0; m_left = 0; m_op = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (m_op == 1) begin
          m_a = (m_a >> 1) | (N'(pa) << (N - 1));
          m_b = (m_b >> 1) | (N'(pb) << (N - 1));
        end else begin
          m_a = m_a << 1;
        end
        m_left--;
        if (m_left == 0) m_done = 1'b1;
      end else if (s && md != 2'd3) begin
        m_cin = pa;
        if (md == 2'd0) begin
          m_a = pa ? '1 : '0;
          m_b = pb ? '1 : '0;
          m_done = 1'b1;
        end else if (md == 2'd1) begin
          m_a = (m_a >> 1) | (N'(pa) << (N - 1));
          m_b = (m_b >> 1) | (N'(pb) << (N - 1));
          m_left = N - 1; m_op = 1;
        end else begin
          m_a = N'(1);
          m_b = pb ? '1 : '0;
          m_left = N - 1; m_op = 2;
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic [1:0] md,
                       input logic pa, input logic pb);
    rst = r; start = s; mode = md; pin_a = pa; pin_b = pb;
    @(posedge clk);
    model_step(r, s, md, pa, pb);
    #1;
    chk("a", a, m_a);
    chk("b", b, m_b);
    chk("cin", N'(cin), N'(m_cin));
    chk("busy", N'(busy), N'(m_left > 0));
    chk("done", N'(done), N'(m_done));
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] da, db, sa, sb;
    int busy_cnt, done_cnt;

    rst = 1'b1; start = 1'b0; mode = 2'd0; pin_a = 1'b0; pin_b = 1'b0;
    m_a = '0; m_b = '0; m_cin = 1'b0; m_done = 1'b0; m_left = 0; m_op = 0;
    @(negedge clk);

    // 1: reset dominates start with pins high
    cycle(1, 1, 2'd1, 1, 1);
    cycle(1, 1, 2'd1, 1, 1);
    cycle(0, 0, 2'd0, 1, 1);
    chk("rst_a", a, '0);
    chk("rst_busy", N'(busy), '0);

    // 2: broadcast
    cycle(0, 1, 2'd0, 1, 0);
    chk("bc_a", a, 16'hFFFF);
    chk("bc_b", b, 16'h0000);
    chk("bc_done", N'(done), N'(1));
    cycle(0, 0, 2'd0, 0, 1);
    chk("bc_done_drop", N'(done), N'(0));

    // 3: serial load
    da = 16'hA5C3; db = 16'h1234; busy_cnt = 0;
    for (int i = 0; i < N; i++) begin
      cycle(0, i == 0, 2'd1, da[i], db[i]);
      if (busy) busy_cnt++;
    end
    chk("ser_busy_cycles", N'(busy_cnt), N'(15));
    chk("ser_a", a, 16'hA5C3);
    chk("ser_b", b, 16'h1234);
    chk("ser_cin", N'(cin), N'(1));
    chk("ser_done", N'(done), N'(1));

    // 4: start during serial ignored; back-to-back start in done cycle
    da = N'($urandom); db = N'($urandom);
    for (int i = 0; i < N; i++) cycle(0, i == 0 || i == 5, (i == 5) ? 2'd0 : 2'd1, da[i], db[i]);
    chk("ign_a", a, da);
    chk("ign_b", b, db);
    cycle(0, 1, 2'd0, 1, 1);
    chk("b2b_a", a, 16'hFFFF);
    chk("b2b_done", N'(done), N'(1));

    // 5: walking one, with stray starts mid-walk
    done_cnt = 0;
    cycle(0, 1, 2'd2, 1'($urandom), 1);
    chk("walk_0", a, N'(1));
    for (int i = 1; i < N; i++) begin
      cycle(0, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
      chk("walk_step", a, N'(1) << i);
      chk("walk_b", b, 16'hFFFF);
      if (done) done_cnt++;
    end
    cycle(0, 0, 2'd0, 0, 0);
    chk("walk_hold", a, 16'h8000);
    chk("walk_done_count", N'(done_cnt), N'(1));

    // 6: reset mid-load, reload, then reserved mode
    for (int i = 0; i < 7; i++) cycle(0, i == 0, 2'd1, 1'($urandom), 1'($urandom));
    cycle(1, 0, 2'd0, 1, 1);
    chk("abort_a", a, '0);
    cycle(0, 0, 2'd0, 1, 1);
    chk("abort_done", N'(done), N'(0));
    da = N'($urandom); db = N'($urandom);
    for (int i = 0; i < N; i++) cycle(0, i == 0, 2'd1, da[i], db[i]);
    chk("reload_a", a, da);
    chk("reload_b", b, db);
    sa = a; sb = b;
    cycle(0, 1, 2'd3, ~da[0], 1);
    cycle(0, 0, 2'd3, 1, 1);
    chk("rsvd_a", a, sa);
    chk("rsvd_b", b, sb);
    chk("rsvd_busy", N'(busy), N'(0));

    // random traffic
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, 2'($urandom),
            1'($urandom), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
